param_dp_memory: RTL and testbench

- Parametrised two-port synchronous-read memory; next generation of the single-port 34-bit x 128 data memory used by the datapath.
- Port A: read/write, valid/ready handshake, registered read data.
- Port B: read-only, for a second consumer (e.g. a loader or debug reader).
- Hardware clear engine zero-sweeps the array on request, one word per cycle, without a reload.

---
 rtl/param_dp_memory_pkg.sv | 19 +
 rtl/param_dp_memory_if.sv | 48 ++++
 rtl/param_dp_memory_clear_fsm.sv | 64 ++++++
 rtl/param_dp_memory.sv | 92 +++++++++
 tb/tb_param_dp_memory.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/param_dp_memory_pkg.sv
// Shared types and defaults for the two-port data memory.
// Consumed by the interface, the clear FSM and the top.
package mem_pkg;

  localparam int DEF_DATA_W = 34;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  // Keep at least one address bit so a 1-deep memory still has a port.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_dp_memory_if.sv
// Port A / port B / clear-control bundle of the two-port memory.
// ADDR_W is derived from DEPTH so both sides always agree.
interface param_dp_memory_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  localparam int ADDR_W = addr_w(DEPTH);

  logic              a_valid;
  logic              a_ready;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_addr,
    output clr_req,
    input  a_ready, a_rvalid, a_rdata,
    input  b_ready, b_rvalid, b_rdata,
    input  clr_busy, clr_done
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_addr,
    input  clr_req,
    output a_ready, a_rvalid, a_rdata,
    output b_ready, b_rvalid, b_rdata,
    output clr_busy, clr_done
  );

endinterface

// File: rtl/param_dp_memory_clear_fsm.sv
// Zero-sweep engine: walks every word once, one per cycle,
// then pulses done. Reset aborts a sweep without a done pulse.
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              idle,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  // clr_req outside IDLE is dropped, never queued.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle       = 1'b0;
    sweep_we   = 1'b0;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    sweep_addr = cnt;
    unique case (state)
      IDLE:    idle = 1'b1;
      CLEAR: begin
        sweep_we = 1'b1;
        clr_busy = 1'b1;
      end
      DONE:    clr_done = 1'b1;
      default: idle = 1'b0;
    endcase
  end

endmodule

// File: rtl/param_dp_memory.sv
// Two-port sync-read memory with hardware zero-sweep.
// Port A read/write, port B read-only, write-first forwarding.
module param_dp_memory
  import mem_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    DEPTH     = DEF_DEPTH,
  parameter string INIT_FILE = "input_memory.txt"
) (
  input  logic               clk,
  input  logic               rst,
  param_dp_memory_if.slave   bus
);

  localparam int ADDR_W = addr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  logic              a_acc;
  logic              a_wr;
  logic              a_rd;
  logic              b_acc;
  logic              a_ok;
  logic              b_ok;
  logic              fwd;

  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  mem_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (bus.clr_req),
    .idle       (idle),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .clr_busy   (bus.clr_busy),
    .clr_done   (bus.clr_done)
  );

  assign bus.a_ready = idle;
  assign bus.b_ready = idle;

  assign a_acc = bus.a_valid & idle & rst;
  assign b_acc = bus.b_valid & idle & rst;
  assign a_wr  = a_acc & bus.a_we;
  assign a_rd  = a_acc & ~bus.a_we;

  assign a_ok  = int'(bus.a_addr) < DEPTH;
  assign b_ok  = int'(bus.b_addr) < DEPTH;
  assign fwd   = a_wr & a_ok & (bus.a_addr == bus.b_addr);

  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[sweep_addr] <= '0;
    else if (a_wr && a_ok)
      mem[bus.a_addr] <= bus.a_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_acc;
      if (a_rd)
        a_rdata <= a_ok ? mem[bus.a_addr] : '0;
      if (b_acc)
        b_rdata <= !b_ok ? '0 :
                   fwd   ? bus.a_wdata :
                           mem[bus.b_addr];
    end
  end

  assign bus.a_rvalid = a_rvalid;
  assign bus.a_rdata  = a_rdata;
  assign bus.b_rvalid = b_rvalid;
  assign bus.b_rdata  = b_rdata;

endmodule

// File: tb/tb_param_dp_memory.sv
// Randomised bench for param_dp_memory against an array model.
// Two instances: DEPTH=128 (main) and DEPTH=100 (range checks).
module tb_param_dp_memory;
  import mem_pkg::*;

  localparam int DW = 34;
  localparam int D0 = 128;
  localparam int D1 = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_dp_memory_if #(.DATA_W(DW), .DEPTH(D0)) bus0 ();
  param_dp_memory_if #(.DATA_W(DW), .DEPTH(D1)) bus1 ();

  param_dp_memory #(.DATA_W(DW), .DEPTH(D0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  param_dp_memory #(.DATA_W(DW), .DEPTH(D1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] ref_mem [D0];
  bit            ref_ok  [D0];
  logic [DW-1:0] last_a  = '0;
  bit            last_ok = 1'b1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic acc0(input bit av, input bit aw, input int aa,
                      input logic [DW-1:0] ad,
                      input bit bv, input int ba);
    logic [DW-1:0] ea, eb;
    bit ka, kb;
    check("a_ready", bus0.a_ready, 1);
    bus0.a_valid = av;
    bus0.a_we    = aw;
    bus0.a_addr  = 7'(aa);
    bus0.a_wdata = ad;
    bus0.b_valid = bv;
    bus0.b_addr  = 7'(ba);
    if (av && aw) begin
      ref_mem[aa] = ad;
      ref_ok[aa]  = 1'b1;
    end
    ea = ref_mem[aa]; ka = ref_ok[aa];
    eb = ref_mem[ba]; kb = ref_ok[ba];
    step;
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;
    check("a_rvalid", bus0.a_rvalid, 64'(av && !aw));
    check("b_rvalid", bus0.b_rvalid, 64'(bv));
    if (av && !aw) begin
      if (ka) check("a_rdata", bus0.a_rdata, ea);
      last_a = ea; last_ok = ka;
    end else if (last_ok) begin
      check("a_hold", bus0.a_rdata, last_a);
    end
    if (bv && kb) check("b_rdata", bus0.b_rdata, eb);
  endtask

  task automatic acc1(input bit aw, input int aa, input logic [DW-1:0] ad);
    bus1.a_valid = 1'b1;
    bus1.a_we    = aw;
    bus1.a_addr  = 7'(aa);
    bus1.a_wdata = ad;
    step;
    bus1.a_valid = 1'b0;
  endtask

  task automatic sweep_watch(input bit poke, output int nb, output int nd);
    int bad;
    bad = 0; nb = 0; nd = 0;
    bus0.clr_req = 1'b1;
    bus0.a_valid = 1'b1;
    bus0.a_we    = 1'b1;
    bus0.a_addr  = 7'(D0 - 1);
    bus0.a_wdata = 34'h1_5555_AAAA;
    step;
    bus0.clr_req = 1'b0;
    bus0.a_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus0.clr_busy) nb++;
      if (bus0.clr_done) nd++;
      if ((bus0.clr_busy || bus0.clr_done) &&
          (bus0.a_ready || bus0.b_ready)) bad++;
      if (bus0.a_rvalid || bus0.b_rvalid) bad++;
      bus0.clr_req = poke && (i == 50 || i == D0);
      bus0.a_valid = poke && (i == 60);
      bus0.b_valid = poke && (i == 60);
      bus0.a_we    = 1'b1;
      bus0.a_addr  = 7'd3;
      bus0.a_wdata = 34'h5;
      bus0.b_addr  = 7'd3;
      step;
    end
    bus0.clr_req = 1'b0;
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;
    check("clr_gate", 64'(bad), 0);
    for (int k = 0; k < D0; k++) begin
      ref_mem[k] = '0;
      ref_ok[k]  = 1'b1;
    end
  endtask

  initial begin
    int nb, nd, aa, ba;
    bit av, aw, bv;
    logic [DW-1:0] ad;

    bus0.a_valid = 0; bus0.a_we = 0; bus0.a_addr = '0; bus0.a_wdata = '0;
    bus0.b_valid = 0; bus0.b_addr = '0; bus0.clr_req = 0;
    bus1.a_valid = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
    bus1.b_valid = 0; bus1.b_addr = '0; bus1.clr_req = 0;

    #2;
    check("rst_a_rvalid", bus0.a_rvalid, 0);
    check("rst_b_rvalid", bus0.b_rvalid, 0);
    check("rst_busy", bus0.clr_busy, 0);
    check("rst_done", bus0.clr_done, 0);
    check("rst_a_rdata", bus0.a_rdata, 0);
    check("rst_b_rdata", bus0.b_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    step;

    acc0(1, 1, 5, 34'h2_DEAD_BEEF, 0, 0);
    acc0(1, 0, 5, '0, 0, 0);
    acc0(1, 1, 9, 34'h1234, 1, 9);

    sweep_watch(0, nb, nd);
    check("busy_cycles", 64'(nb), 128);
    check("done_pulses", 64'(nd), 1);
    acc0(1, 0, 0, '0, 1, 64);
    acc0(1, 0, 127, '0, 1, 5);

    for (int i = 0; i < 150; i++) begin
      av = 1'($urandom);
      aw = 1'($urandom);
      bv = 1'($urandom);
      aa = int'($urandom_range(0, D0 - 1));
      ba = ($urandom_range(0, 3) == 0) ? aa : int'($urandom_range(0, D0 - 1));
      ad = {2'($urandom), 32'($urandom)};
      acc0(av, aw, aa, ad, bv, ba);
    end

    sweep_watch(1, nb, nd);
    check("busy_cycles_req", 64'(nb), 128);
    check("done_once_req", 64'(nd), 1);
    acc0(1, 0, 3, '0, 1, 3);

    for (int k = 0; k <= 10; k++)
      acc0(1, 1, k, 34'(k) + 34'h1_0000_0100, 0, 0);
    acc0(1, 1, 20, 34'h3_0000_0020, 0, 0);
    acc0(1, 0, 20, '0, 0, 0);
    bus0.clr_req = 1'b1;
    step;
    bus0.clr_req = 1'b0;
    repeat (10) step;
    check("busy_before_rst", bus0.clr_busy, 1);
    rst = 1'b0;
    #1;
    check("abort_busy", bus0.clr_busy, 0);
    check("abort_done", bus0.clr_done, 0);
    check("abort_a_rdata", bus0.a_rdata, 0);
    check("abort_ready", bus0.a_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    step;
    last_a = '0; last_ok = 1'b1;
    for (int k = 0; k < 10; k++) ref_mem[k] = '0;
    nd = 0;
    for (int i = 0; i < 140; i++) begin
      if (bus0.clr_done || bus0.clr_busy) nd++;
      step;
    end
    check("no_done_after_abort", 64'(nd), 0);
    for (int k = 0; k <= 10; k++) acc0(1, 0, k, '0, 1, 20);
    acc0(1, 0, 20, '0, 0, 0);

    acc1(1, 10, 34'h155);
    acc1(1, 99, 34'h99);
    acc1(1, 110, 34'h7);
    acc1(0, 99, '0);
    check("d100_rd99", bus1.a_rdata, 34'h99);
    acc1(0, 110, '0);
    check("oor_rvalid", bus1.a_rvalid, 1);
    check("oor_rdata", bus1.a_rdata, 0);
    acc1(0, 10, '0);
    check("d100_rd10", bus1.a_rdata, 34'h155);
    acc1(1, 0, 34'h0);
    check("d100_wr_norv", bus1.a_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
